grant_queue: RTL and testbench
==============================

GRANT_QUEUE -- requirements
Module: grant_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 2, number of entries; legal range 1..64, any value (not limited to powers of two).
REQ-002 SHALL have parameter DATA_W, default 64, width of the data field.
REQ-003 SHALL have parameter PIPE, default 0; when 1, the queue accepts while full if the dequeue fires in the same cycle.
REQ-004 SHALL have parameter FLOW, default 0; when 1, an empty queue passes enqueue data combinationally to dequeue.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 io_enq_ready  out  1  queue can accept this cycle.
REQ-008 io_enq_valid  in  1  producer offers a grant beat.
REQ-009 io_enq_bits_addr_beat  in  3  beat index.
REQ-010 io_enq_bits_client_xact_id  in  2  client transaction id.
REQ-011 io_enq_bits_manager_xact_id  in  1  manager transaction id.
REQ-012 io_enq_bits_is_builtin_type  in  1  built-in grant flag.
REQ-013 io_enq_bits_g_type  in  4  grant type.
REQ-014 io_enq_bits_data  in  DATA_W  payload.
REQ-015 io_deq_ready  in  1  consumer accepts.
REQ-016 io_deq_valid  out  1  head entry available.
REQ-017 io_deq_bits_addr_beat, _client_xact_id, _manager_xact_id, _is_builtin_type, _g_type, _data  out  widths as enq  head entry fields.
REQ-018 io_count  out  clog2(DEPTH+1)  entries currently held.

Function
REQ-019 SHALL store DEPTH entries in a circular buffer with enq_ptr, deq_ptr (clog2(DEPTH) bits, 1 bit minimum) and a maybe_full flag.
REQ-020 Pointers SHALL increment by 1 per fire and wrap from DEPTH-1 to 0 explicitly (no power-of-two assumption).
REQ-021 empty = (enq_ptr==deq_ptr) & !maybe_full; full = (enq_ptr==deq_ptr) & maybe_full.
REQ-022 do_enq = io_enq_ready & io_enq_valid; do_deq = io_deq_ready & io_deq_valid.
REQ-023 On do_enq, the entry at enq_ptr SHALL be written with all six enq fields; it becomes visible at deq one cycle later.
REQ-024 maybe_full SHALL update to do_enq only when do_enq != do_deq; otherwise it holds.
REQ-025 io_enq_ready = !full, OR'd with io_deq_ready when PIPE=1.
REQ-026 io_deq_valid = !empty, OR'd with io_enq_valid when FLOW=1.
REQ-027 FLOW=1 and empty: deq fields SHALL equal enq fields combinationally; if do_deq fires, no write occurs and pointers/maybe_full are unchanged.
REQ-028 Otherwise deq fields SHALL equal the entry at deq_ptr; they hold stable while io_deq_valid & !io_deq_ready.
REQ-029 io_count SHALL equal DEPTH when full, else (enq_ptr - deq_ptr) modulo DEPTH.
REQ-030 Simultaneous enq and deq when neither empty nor full: both pointers advance, count unchanged.
REQ-031 PIPE=1, full, deq fires: enq SHALL be accepted into the freed slot; the queue stays full.
REQ-032 DEPTH=1 SHALL behave as a single-entry buffer with a 1-bit io_count that equals maybe_full.

Reset
REQ-033 Reset assertion SHALL immediately force enq_ptr=0, deq_ptr=0, maybe_full=0, giving io_enq_ready=1, io_deq_valid=0 (FLOW=1: equals io_enq_valid), io_count=0; storage contents are not reset, and reset mid-transfer discards all entries.

Verification
REQ-034 DEPTH=4: enqueue 4 beats with g_type 1,2,3,4, deq_ready=0 -> io_count 1,2,3,4; io_enq_ready=0 after the 4th beat; drain -> g_type order 1,2,3,4, io_deq_valid=0 after the 4th beat.
REQ-035 DEPTH=3: 10 streamed beats with data=i and random deq_ready -> output data sequence 0..9 in order with no loss across pointer wrap; io_count never exceeds 3.
REQ-036 DEPTH=2, PIPE=1, full, enq_valid=deq_ready=1 -> io_enq_ready=1, both fire, io_count stays 2.
REQ-037 DEPTH=2, FLOW=1, empty, enq_valid=1 data=0xA5, deq_ready=1 -> same-cycle io_deq_valid=1, data 0xA5; next cycle io_count=0.
REQ-038 Holding 2 entries, reset pulsed asynchronously between clock edges -> io_deq_valid=0 and io_count=0 immediately; the first post-reset enqueue is dequeued first.

Source files
------------

// File: rtl/grant_queue.sv
// Grant beat queue: DEPTH-entry circular buffer of grant fields with optional pipe/flow modes.
// Latency: one cycle enqueue-to-dequeue; FLOW=1 bypasses an empty queue combinationally.
// Backpressure: io_enq_ready drops when full; PIPE=1 lets a same-cycle dequeue free the slot.
module grant_queue #(
    parameter int DEPTH  = 2,
    parameter int DATA_W = 64,
    parameter int PIPE   = 0,
    parameter int FLOW   = 0
) (
    input  logic                         clk,
    input  logic                         reset,
    output logic                         io_enq_ready,
    input  logic                         io_enq_valid,
    input  logic [2:0]                   io_enq_bits_addr_beat,
    input  logic [1:0]                   io_enq_bits_client_xact_id,
    input  logic                         io_enq_bits_manager_xact_id,
    input  logic                         io_enq_bits_is_builtin_type,
    input  logic [3:0]                   io_enq_bits_g_type,
    input  logic [DATA_W-1:0]            io_enq_bits_data,
    input  logic                         io_deq_ready,
    output logic                         io_deq_valid,
    output logic [2:0]                   io_deq_bits_addr_beat,
    output logic [1:0]                   io_deq_bits_client_xact_id,
    output logic                         io_deq_bits_manager_xact_id,
    output logic                         io_deq_bits_is_builtin_type,
    output logic [3:0]                   io_deq_bits_g_type,
    output logic [DATA_W-1:0]            io_deq_bits_data,
    output logic [$clog2(DEPTH+1)-1:0]   io_count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

    typedef struct packed {
        logic [2:0]        addr_beat;
        logic [1:0]        client_xact_id;
        logic              manager_xact_id;
        logic              is_builtin_type;
        logic [3:0]        g_type;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t           ram [DEPTH];
    entry_t           enq_ent;
    entry_t           head_ent;
    logic [PTR_W-1:0] enq_ptr;
    logic [PTR_W-1:0] deq_ptr;
    logic             maybe_full;
    logic             ptr_match;
    logic             empty;
    logic             full;
    logic             bypass;
    logic             do_enq;
    logic             do_deq;
    logic             wr_en;
    logic             rd_en;
    logic [CNT_W-1:0] enq_c;
    logic [CNT_W-1:0] deq_c;

    function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    assign enq_ent = {io_enq_bits_addr_beat, io_enq_bits_client_xact_id,
                      io_enq_bits_manager_xact_id, io_enq_bits_is_builtin_type,
                      io_enq_bits_g_type, io_enq_bits_data};

    assign ptr_match    = (enq_ptr == deq_ptr);
    assign empty        = ptr_match && !maybe_full;
    assign full         = ptr_match && maybe_full;
    assign bypass       = (FLOW != 0) && empty;
    assign io_enq_ready = !full || ((PIPE != 0) && io_deq_ready);
    assign io_deq_valid = !empty || ((FLOW != 0) && io_enq_valid);
    assign do_enq       = io_enq_ready && io_enq_valid;
    assign do_deq       = io_deq_ready && io_deq_valid;

    // A beat consumed straight through the bypass never touches storage or pointers.
    assign wr_en = do_enq && !(bypass && io_deq_ready);
    assign rd_en = do_deq && !bypass;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            enq_ptr    <= '0;
            deq_ptr    <= '0;
            maybe_full <= 1'b0;
        end else begin
            if (wr_en) enq_ptr <= bump(enq_ptr);
            if (rd_en) deq_ptr <= bump(deq_ptr);
            if (wr_en != rd_en) maybe_full <= wr_en;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) ram[enq_ptr] <= enq_ent;
    end

    assign head_ent = bypass ? enq_ent : ram[deq_ptr];
    assign {io_deq_bits_addr_beat, io_deq_bits_client_xact_id,
            io_deq_bits_manager_xact_id, io_deq_bits_is_builtin_type,
            io_deq_bits_g_type, io_deq_bits_data} = head_ent;

    assign enq_c = CNT_W'(enq_ptr);
    assign deq_c = CNT_W'(deq_ptr);

    // Pointer difference modulo DEPTH; wrap-around sum may overflow but the result fits.
    always_comb begin
        io_count = '0;
        if (full)                io_count = CNT_W'(DEPTH);
        else if (enq_c >= deq_c) io_count = enq_c - deq_c;
        else                     io_count = enq_c + CNT_W'(DEPTH) - deq_c;
    end

endmodule

// File: tb/tb_grant_queue.sv
// Randomized scoreboard bench for grant_queue: four instances (DEPTH 4, DEPTH 3, PIPE, FLOW)
// checked against an occupancy/FIFO reference model.
module tb_grant_queue;

    localparam int NI = 4;
    localparam int DW = 64;

    typedef struct packed {
        logic [2:0]    addr_beat;
        logic [1:0]    client_xact_id;
        logic          manager_xact_id;
        logic          is_builtin_type;
        logic [3:0]    g_type;
        logic [DW-1:0] data;
    } ent_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic       enq_valid [NI];
    logic       deq_ready [NI];
    ent_t       enq_ent   [NI];
    logic       enq_ready [NI];
    logic       deq_valid [NI];
    ent_t       deq_ent   [NI];
    logic [6:0] count     [NI];

    int   checks = 0;
    int   failures = 0;
    int   occ     [NI];
    ent_t exp_q   [NI][$];
    bit   enq_f   [NI];
    bit   deq_f   [NI];
    bit   exp_rdy [NI];
    bit   exp_vld [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int D  = (g == 0) ? 4 : ((g == 1) ? 3 : 2);
        localparam int CW = $clog2(D + 1);
        logic [CW-1:0] cnt;
        logic [2:0]    ab;
        logic [1:0]    cx;
        logic          mx;
        logic          bi;
        logic [3:0]    gt;
        logic [DW-1:0] dt;

        grant_queue #(
            .DEPTH (D),
            .DATA_W(DW),
            .PIPE  ((g == 2) ? 1 : 0),
            .FLOW  ((g == 3) ? 1 : 0)
        ) u_dut (
            .clk                        (clk),
            .reset                      (reset),
            .io_enq_ready               (enq_ready[g]),
            .io_enq_valid               (enq_valid[g]),
            .io_enq_bits_addr_beat      (enq_ent[g].addr_beat),
            .io_enq_bits_client_xact_id (enq_ent[g].client_xact_id),
            .io_enq_bits_manager_xact_id(enq_ent[g].manager_xact_id),
            .io_enq_bits_is_builtin_type(enq_ent[g].is_builtin_type),
            .io_enq_bits_g_type         (enq_ent[g].g_type),
            .io_enq_bits_data           (enq_ent[g].data),
            .io_deq_ready               (deq_ready[g]),
            .io_deq_valid               (deq_valid[g]),
            .io_deq_bits_addr_beat      (ab),
            .io_deq_bits_client_xact_id (cx),
            .io_deq_bits_manager_xact_id(mx),
            .io_deq_bits_is_builtin_type(bi),
            .io_deq_bits_g_type         (gt),
            .io_deq_bits_data           (dt),
            .io_count                   (cnt)
        );

        assign count[g]   = 7'(cnt);
        assign deq_ent[g] = {ab, cx, mx, bi, gt, dt};
    end

    function automatic int dep_of(int g);
        return (g == 0) ? 4 : ((g == 1) ? 3 : 2);
    endfunction

    function automatic bit pipe_of(int g);
        return g == 2;
    endfunction

    function automatic bit flow_of(int g);
        return g == 3;
    endfunction

    function automatic ent_t rand_ent();
        ent_t e;
        e.addr_beat       = 3'($urandom);
        e.client_xact_id  = 2'($urandom);
        e.manager_xact_id = 1'($urandom);
        e.is_builtin_type = 1'($urandom);
        e.g_type          = 4'($urandom);
        e.data            = {$urandom, $urandom};
        return e;
    endfunction

    task automatic check(input string nm, input int g, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d] got=%0h want=%0h at %0t", nm, g, act, exp, $time);
        end
    endtask

    task automatic idle();
        for (int g = 0; g < NI; g++) begin
            enq_valid[g] = 1'b0;
            deq_ready[g] = 1'b0;
            enq_ent[g]   = rand_ent();
        end
    endtask

    // One clock: derive expected handshakes from the model, push accepted beats, check status.
    task automatic tick();
        for (int g = 0; g < NI; g++) begin
            exp_rdy[g] = (occ[g] < dep_of(g)) || (pipe_of(g) && deq_ready[g]);
            exp_vld[g] = (occ[g] > 0) || (flow_of(g) && enq_valid[g]);
            enq_f[g]   = exp_rdy[g] && enq_valid[g];
            deq_f[g]   = exp_vld[g] && deq_ready[g];
            if (enq_f[g]) exp_q[g].push_back(enq_ent[g]);
        end
        @(negedge clk);
        for (int g = 0; g < NI; g++) begin
            check("enq_ready", g, 96'(enq_ready[g]), 96'(exp_rdy[g]));
            check("deq_valid", g, 96'(deq_valid[g]), 96'(exp_vld[g]));
            check("count", g, 96'(count[g]), 96'(occ[g]));
        end
        @(posedge clk);
        for (int g = 0; g < NI; g++) occ[g] += int'(enq_f[g]) - int'(deq_f[g]);
        #1;
    endtask

    task automatic drain_all();
        for (int g = 0; g < NI; g++) begin
            enq_valid[g] = 1'b0;
            deq_ready[g] = 1'b1;
        end
        for (int k = 0; k < 12; k++) tick();
        for (int g = 0; g < NI; g++) begin
            check("drained", g, 96'(exp_q[g].size()), 96'(0));
            deq_ready[g] = 1'b0;
        end
    endtask

    // Monitor: head must match the oldest accepted beat; pop on every DUT dequeue.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                for (int g = 0; g < NI; g++) begin
                    if (deq_valid[g] && exp_q[g].size() > 0)
                        check("head", g, 96'(deq_ent[g]), 96'(exp_q[g][0]));
                    if (deq_valid[g] && deq_ready[g]) begin
                        if (exp_q[g].size() == 0) begin
                            checks++;
                            failures++;
                            $display("FAIL deq_extra[%0d] got=dequeue want=none at %0t", g, $time);
                        end else begin
                            void'(exp_q[g].pop_front());
                        end
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int sent;
        ent_t e;
        idle();
        for (int g = 0; g < NI; g++) occ[g] = 0;
        @(posedge clk);
        #1;
        for (int g = 0; g < NI; g++) begin
            check("rst_enq_ready", g, 96'(enq_ready[g]), 96'(1));
            check("rst_deq_valid", g, 96'(deq_valid[g]), 96'(0));
            check("rst_count", g, 96'(count[g]), 96'(0));
        end
        reset = 1'b0;

        // DEPTH=4 fill with g_type 1..4, then drain in order
        for (int i = 0; i < 4; i++) begin
            enq_valid[0] = 1'b1;
            enq_ent[0] = rand_ent();
            enq_ent[0].g_type = 4'(i + 1);
            tick();
            check("d4_count", 0, 96'(count[0]), 96'(i + 1));
        end
        check("d4_full_ready", 0, 96'(enq_ready[0]), 96'(0));
        enq_valid[0] = 1'b0;
        deq_ready[0] = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check("d4_empty_valid", 0, 96'(deq_valid[0]), 96'(0));
        deq_ready[0] = 1'b0;

        // DEPTH=3 streaming 0..9 with random consumer
        sent = 0;
        for (int k = 0; k < 200 && (sent < 10 || occ[1] > 0); k++) begin
            enq_valid[1] = (sent < 10);
            enq_ent[1] = rand_ent();
            enq_ent[1].data = 64'(sent);
            deq_ready[1] = (sent >= 10) ? 1'b1 : 1'($urandom);
            tick();
            if (enq_f[1]) sent++;
        end
        check("d3_sent", 1, 96'(sent), 96'(10));
        check("d3_drained", 1, 96'(exp_q[1].size()), 96'(0));
        enq_valid[1] = 1'b0;
        deq_ready[1] = 1'b0;

        // PIPE: full queue accepts while dequeuing
        enq_valid[2] = 1'b1;
        for (int i = 0; i < 2; i++) begin
            enq_ent[2] = rand_ent();
            tick();
        end
        enq_ent[2] = rand_ent();
        deq_ready[2] = 1'b1;
        #1;
        check("pipe_ready", 2, 96'(enq_ready[2]), 96'(1));
        tick();
        check("pipe_count", 2, 96'(count[2]), 96'(2));
        enq_valid[2] = 1'b0;
        deq_ready[2] = 1'b0;

        // FLOW: empty queue passes data through in the same cycle
        enq_ent[3] = rand_ent();
        enq_ent[3].data = 64'hA5;
        enq_valid[3] = 1'b1;
        deq_ready[3] = 1'b1;
        #1;
        check("flow_valid", 3, 96'(deq_valid[3]), 96'(1));
        check("flow_data", 3, 96'(deq_ent[3].data), 96'(64'hA5));
        tick();
        enq_valid[3] = 1'b0;
        deq_ready[3] = 1'b0;
        check("flow_count", 3, 96'(count[3]), 96'(0));

        drain_all();

        // Random traffic on all instances, holding offered beats until accepted
        for (int k = 0; k < 400; k++) begin
            for (int g = 0; g < NI; g++) begin
                if (!enq_valid[g] || enq_f[g]) begin
                    enq_valid[g] = 1'($urandom);
                    enq_ent[g] = rand_ent();
                end
                deq_ready[g] = ($urandom_range(0, 3) != 0);
            end
            tick();
        end
        drain_all();

        // Asynchronous reset mid-cycle while holding two entries
        enq_valid[0] = 1'b1;
        for (int i = 0; i < 2; i++) begin
            enq_ent[0] = rand_ent();
            tick();
        end
        idle();
        #2;
        reset = 1'b1;
        #1;
        check("arst_deq_valid", 0, 96'(deq_valid[0]), 96'(0));
        check("arst_count", 0, 96'(count[0]), 96'(0));
        check("arst_enq_ready", 0, 96'(enq_ready[0]), 96'(1));
        for (int g = 0; g < NI; g++) begin
            exp_q[g].delete();
            occ[g] = 0;
        end
        reset = 1'b0;
        @(posedge clk);
        #1;
        enq_valid[0] = 1'b1;
        for (int i = 0; i < 2; i++) begin
            enq_ent[0] = rand_ent();
            enq_ent[0].data = 64'h111 * 64'(i + 1);
            tick();
        end
        enq_valid[0] = 1'b0;
        #1;
        check("post_rst_head", 0, 96'(deq_ent[0].data), 96'(64'h111));
        drain_all();

        e = rand_ent();
        enq_ent[0] = e;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
